onehot_event_encoder: RTL

- Sequential inverse of the team's 3-to-8 one-hot decoder.
- Accepts an 8-bit event vector over a valid/ready input handshake.
- Emits the 3-bit binary index of every set bit, one per output handshake, lowest index first.
- Used where multiple one-hot/multi-hot event lines must be serialised into a 3-bit code stream for a downstream decoder.

---
 rtl/onehot_event_encoder.sv | 106 ++++++++++
 1 files changed

// File: rtl/onehot_event_encoder.sv
// onehot_event_encoder
//   Serialises an 8-bit multi-hot event vector into a stream of 3-bit binary
//   indices, lowest set bit first. This is the sequential inverse of the 3-to-8
//   one-hot decoder.
//
// Ports
//   clk_i       - rising-edge clock
//   rst_n_i     - asynchronous active-low reset
//   in_valid_i  - event vector offered
//   in_ready_o  - block can accept a vector (IDLE)
//   in_vec_i    - event vector; bit i set means event i pending
//   out_valid_o - out_code_o is valid (EMIT)
//   out_ready_i - consumer accepts out_code_o
//   out_code_o  - binary index of the lowest pending event
//   out_last_o  - current code is the final one of its vector
//   zero_err_o  - one-cycle pulse after an all-zero vector was accepted
//   busy_o      - high in EMIT
module onehot_event_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_vec_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_code_o,
  output logic         out_last_o,
  output logic         zero_err_o,
  output logic         busy_o
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           zero_err_q, zero_err_d;
  logic [N-1:0]   pending_minus1;
  logic           single_bit;

  // Priority encoder, bit 0 highest priority. Scanning downwards lets the
  // lowest set bit overwrite any higher one; an empty vector encodes to 0.
  function automatic logic [W-1:0] lowest_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // v & (v-1) clears the lowest set bit; it is zero exactly when at most one
  // bit is set.
  assign pending_minus1 = pending_q - {{(N-1){1'b0}}, 1'b1};
  assign single_bit     = (pending_q != '0) && ((pending_q & pending_minus1) == '0);

  // Outputs decode directly from registered state, so they are glitch-free
  // and drop to reset values as soon as the async reset hits the registers.
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == EMIT);
  assign busy_o      = (state_q == EMIT);
  assign out_code_o  = lowest_index(pending_q);
  assign out_last_o  = single_bit;
  assign zero_err_o  = zero_err_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (in_vec_i != '0) begin
            pending_d = in_vec_i;
            state_d   = EMIT;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready_i) begin
          // On the last code this clears pending to zero as well.
          pending_d = pending_q & pending_minus1;
          if (single_bit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

endmodule
